// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receive and transmit blocks
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rxd synchronizer chain with falling-edge detect
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset to 1 so that reset release on an idle line is not seen as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with oversampled sampling and valid/ack output
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 os_tick,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int                TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]     HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]     FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  logic rxd_s;
  logic fall;

  uart_state_e          state_q;
  logic [TW-1:0]        tcnt_q;
  logic [2:0]           bidx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bidx_q      <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (rx_ack && rx_valid_q) rx_valid_q <= 1'b0;
      if (rx_ack) overrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (fall) begin
            tcnt_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (os_tick) begin
            if (tcnt_q == HALF_LAST) begin
              // A start bit that is high again at its midpoint was only a glitch
              if (!rxd_s) begin
                tcnt_q  <= '0;
                bidx_q  <= '0;
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (os_tick) begin
            if (tcnt_q == FULL_LAST) begin
              shreg_q <= {rxd_s, shreg_q[DATA_BITS-1:1]};
              tcnt_q  <= '0;
              if (bidx_q == LAST_BIT) state_q <= STOP;
              else                    bidx_q  <= bidx_q + 1'b1;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (os_tick) begin
            if (tcnt_q == FULL_LAST) begin
              tcnt_q  <= '0;
              state_q <= IDLE;
              if (rxd_s) begin
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
                // Overwriting a byte that is not being acked this cycle loses it
                if (rx_valid_q && !rx_ack) overrun_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
